// File: rtl/fp_pkg.sv
// Shared widths, FSM states and IEEE-754 packing helper for the FP adder back end.
package fp_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MAN_W   = 23;
  localparam int unsigned SUM_W   = MAN_W + 5;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;
  localparam int unsigned E_W     = 10;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  function automatic logic [31:0] pack_fp(input logic             sign,
                                          input logic [EXP_W-1:0] exp,
                                          input logic [MAN_W-1:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a 27-bit normalized significand {hidden, frac, G, R, S}.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [MAN_W+3:0] m,
  output logic [MAN_W+1:0] r,
  output logic             inexact
);

  logic lsb, grd, rnd, stk, inc;

  assign lsb     = m[3];
  assign grd     = m[2];
  assign rnd     = m[1];
  assign stk     = m[0];
  assign inc     = grd & (lsb | rnd | stk);
  assign inexact = grd | rnd | stk;

  // r[MAN_W+1] catches the carry out of an all-ones significand
  assign r = {1'b0, m[MAN_W+3:3]} + (MAN_W+2)'(inc);

endmodule

// File: rtl/fp_norm_round.sv
// Iterative normalize (one bit per cycle), round-to-nearest-even and pack stage
// of the single-precision adder, with valid/ready on both sides.
module fp_norm_round
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_inexact,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic             out_zero
);

  localparam logic signed [E_W-1:0] E_ONE   = E_W'(1);
  localparam logic signed [E_W-1:0] E_MAX_S = E_W'(EXP_MAX);

  state_t                state;
  logic [SUM_W-2:0]      m_q;
  logic signed [E_W-1:0] e_q;
  logic                  sign_q;
  logic                  zero_q;

  logic signed [E_W-1:0] e_in;
  logic signed [E_W-1:0] e_rnd;
  logic [MAN_W+1:0]      r;
  logic [MAN_W:0]        r_n;
  logic                  inexact;

  fp_round_rne u_round (
    .m       (m_q),
    .r       (r),
    .inexact (inexact)
  );

  // A zero exponent field is treated as the minimum normal exponent
  assign e_in  = (in_exp == '0) ? E_ONE : E_W'(in_exp);
  assign r_n   = r[MAN_W+1] ? r[MAN_W+1:1] : r[MAN_W:0];
  assign e_rnd = r[MAN_W+1] ? e_q + E_ONE : e_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      m_q           <= '0;
      e_q           <= '0;
      sign_q        <= 1'b0;
      zero_q        <= 1'b0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_inexact   <= 1'b0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            sign_q   <= in_sign;
            zero_q   <= (in_sum == '0);
            if (in_sum == '0) begin
              // Zero skips normalization; packing happens in ROUND
              m_q   <= '0;
              e_q   <= e_in;
              state <= ROUND;
            end else if (in_sum[SUM_W-1]) begin
              m_q   <= {in_sum[SUM_W-1:2], in_sum[1] | in_sum[0]};
              e_q   <= e_in + E_ONE;
              state <= NORM;
            end else begin
              m_q   <= in_sum[SUM_W-2:0];
              e_q   <= e_in;
              state <= NORM;
            end
          end
        end

        NORM: begin
          if (m_q[SUM_W-2] || (e_q == E_ONE)) begin
            state <= ROUND;
          end else begin
            m_q <= {m_q[SUM_W-3:0], 1'b0};
            e_q <= e_q - E_ONE;
          end
        end

        ROUND: begin
          out_valid <= 1'b1;
          state     <= DONE;
          if (zero_q) begin
            out_result    <= pack_fp(sign_q, '0, '0);
            out_zero      <= 1'b1;
            out_inexact   <= 1'b0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
          end else if (e_rnd >= E_MAX_S) begin
            out_result    <= pack_fp(sign_q, '1, '0);
            out_zero      <= 1'b0;
            out_inexact   <= inexact;
            out_overflow  <= 1'b1;
            out_underflow <= 1'b0;
          end else begin
            // Subnormals (hidden bit clear) pack with a zero exponent field
            out_result    <= pack_fp(sign_q, r_n[MAN_W] ? e_rnd[EXP_W-1:0] : '0,
                                     r_n[MAN_W-1:0]);
            out_zero      <= 1'b0;
            out_inexact   <= inexact;
            out_overflow  <= 1'b0;
            out_underflow <= ~r_n[MAN_W] & inexact;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed and pseudo-random check of fp_norm_round against an arithmetic reference model.
module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [27:0] in_sum = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_inexact;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_zero;

  fp_norm_round dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_sum        (in_sum),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_inexact   (out_inexact),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_zero      (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        inx;
    logic        ovf;
    logic        unf;
    logic        zr;
    int          lat;
    longint      cyc;
  } exp_t;

  exp_t        q[$];
  longint      cyc = 0;
  int          errors = 0;
  int          checks = 0;
  bit          seen = 1'b0;
  logic [31:0] last_res;
  logic [3:0]  last_flags;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: value-level normalize, round half to even, pack
  function automatic exp_t model(input logic s, input logic [7:0] ex, input logic [27:0] sum);
    exp_t   x;
    longint m, keep, rem;
    int     e, n;
    x = '0;
    if (sum == 0) begin
      x.res = {s, 31'b0};
      x.zr  = 1'b1;
      x.lat = 1;
      return x;
    end
    e = (ex == 0) ? 1 : int'(ex);
    m = longint'(sum);
    if (m >= (longint'(1) << 27)) begin
      m = ((m >> 2) << 1) | (((m & 3) != 0) ? 1 : 0);
      e++;
    end
    n = 0;
    while (m < (longint'(1) << 26) && e > 1) begin
      m = m * 2;
      e--;
      n++;
    end
    keep = m >> 3;
    rem  = m & 7;
    if (rem > 4 || (rem == 4 && (keep % 2) == 1)) keep++;
    if (keep >= (longint'(1) << 24)) begin
      keep = keep / 2;
      e++;
    end
    x.inx = (rem != 0);
    x.lat = n + 2;
    if (e >= 255) begin
      x.res = {s, 8'hFF, 23'h0};
      x.ovf = 1'b1;
    end else begin
      x.res = {s, (keep >= (longint'(1) << 23)) ? 8'(e) : 8'h00, keep[22:0]};
      x.unf = (keep < (longint'(1) << 23)) && x.inx;
    end
    return x;
  endfunction

  // Single compare process: every cycle out_valid is high, check against the queue head
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 32'(out_valid), 32'd0);
        end else begin
          if (!seen) begin
            chk("latency", 32'(cyc), 32'(q[0].cyc));
            seen = 1'b1;
          end
          chk("result", out_result, q[0].res);
          chk("flags", {28'd0, out_inexact, out_overflow, out_underflow, out_zero},
              {28'd0, q[0].inx, q[0].ovf, q[0].unf, q[0].zr});
          chk("in_ready_busy", 32'(in_ready), 32'd0);
          if (out_ready) begin
            last_res   = out_result;
            last_flags = {out_inexact, out_overflow, out_underflow, out_zero};
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end else if (q.size() != 0 && cyc > q[0].cyc) begin
        chk("late_valid", 32'(out_valid), 32'd1);
        void'(q.pop_front());
        seen = 1'b0;
      end
    end
  end

  task automatic send(input logic s, input logic [7:0] e, input logic [27:0] sum);
    int   w;
    exp_t x;
    @(negedge clk);
    in_sign  = s;
    in_exp   = e;
    in_sum   = sum;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = model(s, e, sum);
    x.cyc = cyc + longint'(x.lat);
    q.push_back(x);
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", 32'(q.size()), 32'd0);
      q.delete();
      seen = 1'b0;
    end
    @(negedge clk);
  endtask

  // Directed vector: hand-computed result, flags {inexact, overflow, underflow, zero}, latency
  task automatic run_lit(input string name, input logic s, input logic [7:0] e,
                         input logic [27:0] sum, input logic [31:0] res,
                         input logic [3:0] flags, input int lat);
    exp_t x;
    x = model(s, e, sum);
    chk({name, "_model_lat"}, 32'(x.lat), 32'(lat));
    chk({name, "_model_res"}, x.res, res);
    send(s, e, sum);
    wait_done();
    chk({name, "_res"}, last_res, res);
    chk({name, "_flags"}, {28'd0, last_flags}, {28'd0, flags});
  endtask

  initial begin
    #500000;
    chk("watchdog", 32'd1, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_outputs", {out_result[30:0], out_valid},
        {31'd0, 1'b0});
    chk("rst_out_flags", {28'd0, out_inexact, out_overflow, out_underflow, out_zero}, 32'd0);
    rst = 1'b0;

    run_lit("norm",       1'b0, 8'd127, 28'h4000000, 32'h3F800000, 4'b0000, 2);
    run_lit("carry",      1'b0, 8'd127, 28'h8000000, 32'h40000000, 4'b0000, 2);
    run_lit("deep",       1'b0, 8'd150, 28'h0000008, 32'h3F800000, 4'b0000, 25);
    run_lit("tie_even",   1'b0, 8'd127, 28'h4000004, 32'h3F800000, 4'b1000, 2);
    run_lit("tie_odd",    1'b0, 8'd127, 28'h400000C, 32'h3F800002, 4'b1000, 2);
    run_lit("ovf",        1'b0, 8'd254, 28'h8000000, 32'h7F800000, 4'b0100, 2);
    run_lit("subnorm",    1'b0, 8'd3,   28'h0000010, 32'h00000008, 4'b0000, 4);
    run_lit("zero",       1'b1, 8'd200, 28'h0000000, 32'h80000000, 4'b0001, 1);
    run_lit("sub_inx",    1'b0, 8'd1,   28'h0000007, 32'h00000001, 4'b1010, 2);
    run_lit("sub_hidden", 1'b0, 8'd1,   28'h3FFFFFC, 32'h00800000, 4'b1000, 2);
    run_lit("rnd_carry",  1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 4'b1000, 2);
    run_lit("exp0",       1'b1, 8'd0,   28'h4000000, 32'h80800000, 4'b0000, 2);
    run_lit("rnd_ovf",    1'b0, 8'd254, 28'h7FFFFFF, 32'h7F800000, 4'b1100, 2);

    // Backpressure: result must hold while the consumer stalls
    out_ready = 1'b0;
    send(1'b0, 8'd127, 28'h400000C);
    for (int w = 0; w < 50 && !out_valid; w++) @(negedge clk);
    chk("bp_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_result", out_result, 32'h3F800002);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done();

    // Asynchronous reset in the middle of normalization drops the operand
    send(1'b0, 8'd150, 28'h0000008);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    q.delete();
    seen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    run_lit("post_rst", 1'b0, 8'd127, 28'h8000000, 32'h40000000, 4'b0000, 2);

    // Pseudo-random operands checked against the model only
    for (int i = 0; i < 24; i++) begin
      logic [27:0] sum;
      sum = 28'($urandom) >> $urandom_range(0, 27);
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), sum);
      wait_done();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
